// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load/config inputs and scan outputs of the seven-segment scan controller
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] i_value;
    logic                i_load;
    logic                i_lz_en;
    logic [DIGITS-1:0]   i_blink_mask;
    logic [3:0]          o_digit;
    logic [DIGITS-1:0]   o_an;
    logic                o_frame;
    logic                o_load_ack;

    modport master (
        output i_value, i_load, i_lz_en, i_blink_mask,
        input  o_digit, o_an, o_frame, o_load_ack
    );

    modport slave (
        input  i_value, i_load, i_lz_en, i_blink_mask,
        output o_digit, o_an, o_frame, o_load_ack
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan with dead time, leading-zero blanking, blink and frame-aligned commit
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DIV          = 50000,
    parameter int DEAD         = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {S_DEAD, S_ON} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [4*DIGITS-1:0] act, act_nxt, pend;
    logic                pend_v;
    logic [FW-1:0]       fcnt;
    logic                bph;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          digit_nxt;
    logic                zero_run;
    logic                slot_end, frame_end, commit;

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
    assign commit    = frame_end && (pend_v || bus.i_load);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        case (state)
            S_DEAD:  if (cnt == CW'(DEAD - 1)) state_nxt = S_ON;
            S_ON:    if (slot_end) state_nxt = S_DEAD;
            default: state_nxt = S_DEAD;
        endcase
        if (slot_end) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // o_digit is registered from next-cycle values so it moves on the same edge as idx
    always_comb begin
        act_nxt   = commit ? (bus.i_load ? bus.i_value : pend) : act;
        digit_nxt = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IW'(k)) digit_nxt = act_nxt[4*k +: 4];
        end
    end

    // Scan from the most significant digit down; a digit is a leading zero while all above it are zero
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (act[4*k +: 4] != 4'd0) zero_run = 1'b0;
            blank[k] = (bus.i_lz_en && zero_run && (k != 0)) || (bph && bus.i_blink_mask[k]);
        end
    end

    always_comb begin
        bus.o_an = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (state == S_ON && idx == IW'(k) && !blank[k]) bus.o_an[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_DEAD;
            cnt            <= '0;
            idx            <= '0;
            act            <= '0;
            pend           <= '0;
            pend_v         <= 1'b0;
            fcnt           <= '0;
            bph            <= 1'b0;
            bus.o_digit    <= 4'd0;
            bus.o_frame    <= 1'b0;
            bus.o_load_ack <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            act            <= act_nxt;
            bus.o_digit    <= digit_nxt;
            bus.o_frame    <= frame_end;
            bus.o_load_ack <= commit;
            if (commit) begin
                pend_v <= 1'b0;
            end else if (bus.i_load) begin
                pend   <= bus.i_value;
                pend_v <= 1'b1;
            end
            if (frame_end) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt <= '0;
                    bph  <= ~bph;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized and directed bench for seg_scan_ctrl against a cycle-index reference model
module tb_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;
    localparam int BF     = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;
    logic [15:0] m_act, m_pend;
    bit m_pv, m_ack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_clear();
        t = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 0; m_ack = 0;
    endtask

    task automatic do_reset();
        bus.i_load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One cycle: drive inputs, compare against the model for cycle t, advance model, move to next negedge
    task automatic step(input bit ld, input logic [15:0] val, input bit lz, input logic [3:0] mask);
        int idx, pos, bph;
        bit blank;
        logic [3:0] exp_an;
        bus.i_load = ld; bus.i_value = val; bus.i_lz_en = lz; bus.i_blink_mask = mask;
        #1;
        idx = (t / DIV) % DIGITS;
        pos = t % DIV;
        bph = ((t / FRAME) / BF) % 2;
        exp_an = 4'hF;
        if (pos >= DEAD) begin
            blank = (lz && idx != 0 && (m_act >> (4 * idx)) == 16'h0) || (bph == 1 && mask[idx]);
            if (!blank) exp_an[idx] = 1'b0;
        end
        check_eq("an", 32'(bus.o_an), 32'(exp_an));
        check_eq("digit", 32'(bus.o_digit), 32'((m_act >> (4 * idx)) & 16'hF));
        check_eq("frame", 32'(bus.o_frame), 32'(t > 0 && t % FRAME == 0));
        check_eq("ack", 32'(bus.o_load_ack), 32'(m_ack));
        m_ack = 0;
        if (t % FRAME == FRAME - 1) begin
            if (m_pv || ld) begin
                m_act = ld ? val : m_pend;
                m_pv  = 0;
                m_ack = 1;
            end
        end else if (ld) begin
            m_pend = val;
            m_pv   = 1;
        end
        t++;
        @(negedge clk);
    endtask

    initial begin
        bit lz;
        logic [3:0] mask;
        bus.i_value = '0; bus.i_load = 1'b0; bus.i_lz_en = 1'b0; bus.i_blink_mask = '0;
        model_clear();

        do_reset();
        for (int i = 0; i < 40; i++) step(0, 16'h0, 0, 4'h0);

        do_reset();
        for (int i = 0; i < 96; i++) step(i == 5, 16'h1234, 0, 4'h0);

        do_reset();
        for (int i = 0; i < 72; i++)
            step(i == 5 || i == 20 || i == 63,
                 (i == 5) ? 16'h1111 : (i == 20) ? 16'h2222 : 16'h3333, 0, 4'h0);

        do_reset();
        for (int i = 0; i < 130; i++)
            step(i == 5 || i == 64, (i < 64) ? 16'h0050 : 16'h0000, 1, 4'h0);

        do_reset();
        for (int i = 0; i < 6 * FRAME; i++) step(i == 3, 16'h8421, 0, 4'b0001);

        do_reset();
        lz = 0; mask = 4'h0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 63) == 0) lz = ~lz;
            if ($urandom_range(0, 63) == 0) mask = 4'($urandom);
            step($urandom_range(0, 15) == 0, 16'($urandom), lz, mask);
        end

        // Reset mid-slot right after a load: anodes off at once, value and ack discarded
        do_reset();
        for (int i = 0; i < 42; i++) step(i == 3 || i == 40, (i == 3) ? 16'h5678 : 16'h9999, 0, 4'h0);
        bus.i_load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_an", 32'(bus.o_an), 32'hF);
        check_eq("rst_digit", 32'(bus.o_digit), 32'h0);
        check_eq("rst_ack", 32'(bus.o_load_ack), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 70; i++) step(0, 16'h0, 0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
